// File: rtl/spi_apb_arbiter.sv
// rtl/spi_apb_arbiter.sv - round-robin arbiter sharing one APB master port between NUM_REQ requesters
module spi_apb_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_WIDE = 32,
  parameter int DATA_WIDE = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                           clk_i,
  input  logic                           resetn_i,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ-1:0]             req_write_i,
  input  logic [NUM_REQ*ADDR_WIDE-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_WIDE-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic [NUM_REQ-1:0]             done_o,
  output logic                           err_o,
  output logic [DATA_WIDE-1:0]           rdata_o,
  output logic [ADDR_WIDE-1:0]           paddr_o,
  output logic                           pwrite_o,
  output logic                           psel_o,
  output logic                           penable_o,
  output logic [DATA_WIDE-1:0]           pwdata_o,
  input  logic [DATA_WIDE-1:0]           prdata_i,
  input  logic                           pready_i,
  input  logic                           pslverr_i
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t                 r_state, w_state_n;
  logic [PW-1:0]          r_ptr, w_ptr_n;
  logic [PW-1:0]          r_owner, w_owner_n;
  logic [CW-1:0]          r_cnt, w_cnt_n;
  logic [NUM_REQ-1:0]     r_grant, w_grant_n;
  logic [NUM_REQ-1:0]     r_done, w_done_n;
  logic                   r_err, w_err_n;
  logic [DATA_WIDE-1:0]   r_rdata, w_rdata_n;
  logic [ADDR_WIDE-1:0]   r_paddr, w_paddr_n;
  logic                   r_pwrite, w_pwrite_n;
  logic                   r_psel, w_psel_n;
  logic                   r_penable, w_penable_n;
  logic [DATA_WIDE-1:0]   r_pwdata, w_pwdata_n;

  logic [NUM_REQ-1:0]     w_elig;
  logic                   w_any;
  logic [PW-1:0]          w_sel;
  logic [PW-1:0]          w_cand;
  int                     w_j;
  logic                   w_tmo;
  logic [PW-1:0]          w_ptr_inc;

  // The owner just completed is masked so a held request cannot be re-granted in its own done cycle.
  assign w_elig    = req_i & ~r_done;
  assign w_tmo     = (r_state == S_ACCESS) && !pready_i && (r_cnt == CW'(TIMEOUT - 1));
  assign w_ptr_inc = (r_owner == PW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

  // Scan from the highest offset down so the lowest offset from r_ptr wins.
  always_comb begin
    w_any  = 1'b0;
    w_sel  = '0;
    w_j    = 0;
    w_cand = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_j    = (int'(r_ptr) + i) % NUM_REQ;
      w_cand = PW'(w_j);
      if (w_elig[w_cand]) begin
        w_any = 1'b1;
        w_sel = w_cand;
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwdata  <= '0;
    end else begin
      r_state   <= w_state_n;
      r_ptr     <= w_ptr_n;
      r_owner   <= w_owner_n;
      r_cnt     <= w_cnt_n;
      r_grant   <= w_grant_n;
      r_done    <= w_done_n;
      r_err     <= w_err_n;
      r_rdata   <= w_rdata_n;
      r_paddr   <= w_paddr_n;
      r_pwrite  <= w_pwrite_n;
      r_psel    <= w_psel_n;
      r_penable <= w_penable_n;
      r_pwdata  <= w_pwdata_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_state_n = S_SETUP;
      S_SETUP:  w_state_n = S_ACCESS;
      S_ACCESS: if (pready_i || w_tmo) w_state_n = S_IDLE;
      default:  w_state_n = S_IDLE;
    endcase
  end

  always_comb begin
    w_ptr_n     = r_ptr;
    w_owner_n   = r_owner;
    w_cnt_n     = r_cnt;
    w_grant_n   = r_grant;
    w_done_n    = '0;
    w_err_n     = 1'b0;
    w_rdata_n   = '0;
    w_paddr_n   = r_paddr;
    w_pwrite_n  = r_pwrite;
    w_psel_n    = r_psel;
    w_penable_n = r_penable;
    w_pwdata_n  = r_pwdata;
    case (r_state)
      S_IDLE: begin
        w_penable_n = 1'b0;
        if (w_any) begin
          w_owner_n        = w_sel;
          w_grant_n        = '0;
          w_grant_n[w_sel] = 1'b1;
          w_psel_n         = 1'b1;
          w_paddr_n        = req_addr_i[w_sel*ADDR_WIDE +: ADDR_WIDE];
          w_pwrite_n       = req_write_i[w_sel];
          w_pwdata_n       = req_wdata_i[w_sel*DATA_WIDE +: DATA_WIDE];
        end else begin
          w_grant_n  = '0;
          w_psel_n   = 1'b0;
          w_paddr_n  = '0;
          w_pwrite_n = 1'b0;
          w_pwdata_n = '0;
        end
      end
      S_SETUP: begin
        w_penable_n = 1'b1;
        w_cnt_n     = '0;
      end
      S_ACCESS: begin
        if (pready_i || w_tmo) begin
          w_done_n[r_owner] = 1'b1;
          w_err_n           = w_tmo ? 1'b1 : pslverr_i;
          w_rdata_n         = (w_tmo || r_pwrite) ? '0 : prdata_i;
          w_ptr_n           = w_ptr_inc;
          w_grant_n         = '0;
          w_psel_n          = 1'b0;
          w_penable_n       = 1'b0;
          w_paddr_n         = '0;
          w_pwrite_n        = 1'b0;
          w_pwdata_n        = '0;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: begin
        w_grant_n   = '0;
        w_psel_n    = 1'b0;
        w_penable_n = 1'b0;
      end
    endcase
  end

  assign grant_o   = r_grant;
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign rdata_o   = r_rdata;
  assign paddr_o   = r_paddr;
  assign pwrite_o  = r_pwrite;
  assign psel_o    = r_psel;
  assign penable_o = r_penable;
  assign pwdata_o  = r_pwdata;

endmodule

// File: tb/tb_spi_apb_arbiter.sv
// tb/tb_spi_apb_arbiter.sv - directed testbench for spi_apb_arbiter
module tb_spi_apb_arbiter;
  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic             clk_i = 1'b0;
  logic             resetn_i;
  logic [NR-1:0]    req_i;
  logic [NR-1:0]    req_write_i;
  logic [NR*AW-1:0] req_addr_i;
  logic [NR*DW-1:0] req_wdata_i;
  logic [NR-1:0]    grant_o;
  logic [NR-1:0]    done_o;
  logic             err_o;
  logic [DW-1:0]    rdata_o;
  logic [AW-1:0]    paddr_o;
  logic             pwrite_o;
  logic             psel_o;
  logic             penable_o;
  logic [DW-1:0]    pwdata_o;
  logic [DW-1:0]    prdata_i;
  logic             pready_i;
  logic             pslverr_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  spi_apb_arbiter #(.NUM_REQ(NR), .ADDR_WIDE(AW), .DATA_WIDE(DW), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .resetn_i(resetn_i), .req_i(req_i), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .grant_o(grant_o), .done_o(done_o),
    .err_o(err_o), .rdata_o(rdata_o), .paddr_o(paddr_o), .pwrite_o(pwrite_o), .psel_o(psel_o),
    .penable_o(penable_o), .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i),
    .pslverr_i(pslverr_i)
  );

  task automatic do_reset();
    resetn_i = 1'b0;
    req_i = '0; req_write_i = '0; req_addr_i = '0; req_wdata_i = '0;
    prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
    repeat (2) @(negedge clk_i);
    resetn_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({grant_o, done_o, err_o, rdata_o, paddr_o, pwrite_o, psel_o, penable_o, pwdata_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: psel=%0b penable=%0b grant=%b done=%b paddr=%h expected all zero",
               psel_o, penable_o, grant_o, done_o, paddr_o);
    end
  endtask

  task automatic test_single_write();
    req_write_i = 2'b01; req_addr_i[0 +: AW] = 32'h10; req_wdata_i[0 +: DW] = 32'hA5A5_0001;
    req_i = 2'b01; pready_i = 1'b1;
    @(negedge clk_i);
    n_tests++;
    if ({psel_o, penable_o, grant_o, paddr_o, pwrite_o, pwdata_o} !== {1'b1, 1'b0, 2'b01, 32'h10, 1'b1, 32'hA5A5_0001}) begin
      n_fail++;
      $display("FAIL wr_setup: psel=%0b pen=%0b grant=%b paddr=%h pwrite=%0b pwdata=%h expected 1 0 01 10 1 a5a50001",
               psel_o, penable_o, grant_o, paddr_o, pwrite_o, pwdata_o);
    end
    @(negedge clk_i);
    n_tests++;
    if ({psel_o, penable_o, grant_o, done_o} !== {1'b1, 1'b1, 2'b01, 2'b00}) begin
      n_fail++;
      $display("FAIL wr_access: psel=%0b pen=%0b grant=%b done=%b expected 1 1 01 00", psel_o, penable_o, grant_o, done_o);
    end
    @(negedge clk_i);
    n_tests++;
    if ({done_o, err_o, rdata_o, psel_o, penable_o, grant_o, paddr_o} !== {2'b01, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0}) begin
      n_fail++;
      $display("FAIL wr_done: done=%b err=%0b rdata=%h psel=%0b grant=%b paddr=%h expected 01 0 0 0 00 0",
               done_o, err_o, rdata_o, psel_o, grant_o, paddr_o);
    end
    req_i = 2'b00;
    @(negedge clk_i);
    n_tests++;
    if ({psel_o, done_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL wr_idle: psel=%0b done=%b expected 0 00", psel_o, done_o);
    end
  endtask

  task automatic test_contention();
    logic [NR-1:0] gseq [4];
    logic [NR-1:0] dseq [4];
    logic [DW-1:0] rseq [4];
    int ng = 0;
    int nd = 0;
    do_reset();
    req_write_i = 2'b00; req_addr_i = {32'h200, 32'h100}; req_i = 2'b11; pready_i = 1'b1;
    for (int c = 0; c < 20 && nd < 2; c++) begin
      @(negedge clk_i);
      prdata_i = grant_o[1] ? 32'h22 : 32'h11;
      if (psel_o && !penable_o && ng < 4) begin gseq[ng] = grant_o; ng++; end
      if (done_o != '0 && nd < 4) begin
        dseq[nd] = done_o; rseq[nd] = rdata_o; nd++;
        req_i = req_i & ~done_o;
      end
    end
    n_tests++;
    if (ng != 2 || nd != 2) begin
      n_fail++;
      $display("FAIL cont_count: grants=%0d dones=%0d expected 2 2", ng, nd);
    end else begin
      n_tests++;
      if ({gseq[0], gseq[1]} !== 4'b0110) begin
        n_fail++;
        $display("FAIL cont_grants: %b %b expected 01 10", gseq[0], gseq[1]);
      end
      n_tests++;
      if ({dseq[0], rseq[0], dseq[1], rseq[1]} !== {2'b01, 32'h11, 2'b10, 32'h22}) begin
        n_fail++;
        $display("FAIL cont_done: %b/%h %b/%h expected 01/11 10/22", dseq[0], rseq[0], dseq[1], rseq[1]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [NR-1:0] gseq [6];
    logic [NR-1:0] prev_done;
    int ng = 0;
    int bad_regrant = 0;
    prev_done = '0;
    req_write_i = 2'b11; req_i = 2'b11; pready_i = 1'b1;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      @(negedge clk_i);
      if (psel_o && !penable_o) begin
        if ((grant_o & prev_done) != '0) bad_regrant++;
        gseq[ng] = grant_o; ng++;
      end
      prev_done = done_o;
    end
    req_i = 2'b00;
    repeat (4) @(negedge clk_i);
    n_tests++;
    if (ng != 6) begin
      n_fail++;
      $display("FAIL fair_count: grants=%0d expected 6", ng);
    end else begin
      n_tests++;
      if ({gseq[0], gseq[1], gseq[2], gseq[3], gseq[4], gseq[5]} !== 12'b01_10_01_10_01_10) begin
        n_fail++;
        $display("FAIL fair_order: %b %b %b %b %b %b expected 01 10 01 10 01 10",
                 gseq[0], gseq[1], gseq[2], gseq[3], gseq[4], gseq[5]);
      end
    end
    n_tests++;
    if (bad_regrant != 0) begin
      n_fail++;
      $display("FAIL fair_regrant: %0d grants coincided with own done, expected 0", bad_regrant);
    end
    n_tests++;
    if ({psel_o, grant_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL fair_idle: psel=%0b grant=%b expected 0 00", psel_o, grant_o);
    end
  endtask

  task automatic test_wait_states();
    int unstable = 0;
    req_write_i = 2'b00; req_addr_i[0 +: AW] = 32'h44; prdata_i = 32'hDEAD_BEEF;
    req_i = 2'b01; pready_i = 1'b0;
    @(negedge clk_i);
    for (int a = 1; a <= 4; a++) begin
      @(negedge clk_i);
      if ({psel_o, penable_o, grant_o, paddr_o, pwrite_o, done_o} !== {1'b1, 1'b1, 2'b01, 32'h44, 1'b0, 2'b00})
        unstable++;
      pready_i = (a == 4);
    end
    n_tests++;
    if (unstable != 0) begin
      n_fail++;
      $display("FAIL ws_stable: %0d ACCESS cycles with wrong APB outputs, expected 0", unstable);
    end
    @(negedge clk_i);
    n_tests++;
    if ({done_o, err_o, rdata_o} !== {2'b01, 1'b0, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL ws_done: done=%b err=%0b rdata=%h expected 01 0 deadbeef", done_o, err_o, rdata_o);
    end
    req_i = 2'b00; pready_i = 1'b0;
    @(negedge clk_i);
    req_write_i = 2'b10; req_addr_i[AW +: AW] = 32'h80; req_wdata_i[DW +: DW] = 32'h1234;
    req_i = 2'b10; pready_i = 1'b1; pslverr_i = 1'b1;
    for (int c = 0; c < 10 && done_o == '0; c++) @(negedge clk_i);
    n_tests++;
    if ({done_o, err_o, rdata_o} !== {2'b10, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL ws_slverr: done=%b err=%0b rdata=%h expected 10 1 0", done_o, err_o, rdata_o);
    end
    req_i = 2'b00; pslverr_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_timeout();
    int acc = 0;
    req_write_i = 2'b00; req_addr_i[0 +: AW] = 32'h60; prdata_i = 32'h5555_5555;
    req_i = 2'b01; pready_i = 1'b0;
    for (int c = 0; c < 40 && done_o == '0; c++) begin
      @(negedge clk_i);
      if (psel_o && penable_o) acc++;
    end
    n_tests++;
    if (acc != 16) begin
      n_fail++;
      $display("FAIL tmo_cycles: access cycles=%0d expected 16", acc);
    end
    n_tests++;
    if ({done_o, err_o, rdata_o} !== {2'b01, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL tmo_done: done=%b err=%0b rdata=%h expected 01 1 0", done_o, err_o, rdata_o);
    end
    req_i = 2'b00;
    @(negedge clk_i);
    prdata_i = 32'h77; req_i = 2'b01; pready_i = 1'b1;
    for (int c = 0; c < 10 && done_o == '0; c++) @(negedge clk_i);
    n_tests++;
    if ({done_o, err_o, rdata_o} !== {2'b01, 1'b0, 32'h77}) begin
      n_fail++;
      $display("FAIL tmo_recover: done=%b err=%0b rdata=%h expected 01 0 77", done_o, err_o, rdata_o);
    end
    req_i = 2'b00;
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid_access();
    logic [NR-1:0] gseq [2];
    int ng = 0;
    req_write_i = 2'b01; req_addr_i[0 +: AW] = 32'h30; req_i = 2'b01; pready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    n_tests++;
    if ({psel_o, penable_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_pre: psel=%0b pen=%0b expected 1 1", psel_o, penable_o);
    end
    resetn_i = 1'b0;
    req_i = 2'b11;
    #1;
    n_tests++;
    if ({psel_o, penable_o, grant_o, done_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL rst_async: psel=%0b pen=%0b grant=%b done=%b expected 0 0 00 00", psel_o, penable_o, grant_o, done_o);
    end
    @(negedge clk_i);
    resetn_i = 1'b1; pready_i = 1'b1;
    for (int c = 0; c < 20 && ng < 2; c++) begin
      @(negedge clk_i);
      if (psel_o && !penable_o) begin gseq[ng] = grant_o; ng++; end
      if (done_o != '0) req_i = req_i & ~done_o;
    end
    n_tests++;
    if (ng != 2 || {gseq[0], gseq[1]} !== 4'b0110) begin
      n_fail++;
      $display("FAIL rst_order: count=%0d grants=%b %b expected 2 01 10", ng, gseq[0], gseq[1]);
    end
    req_i = 2'b00;
    repeat (3) @(negedge clk_i);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_fairness();
    test_wait_states();
    test_timeout();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
